branch_ctrl: RTL
================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter PERF_W, default 32: width of the performance counters.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 branchD  in  1  a conditional branch occupies Decode.
REQ-005 take_branch  in  1  branch unit outcome; valid only while branchD=1.
REQ-006 target_D  in  32  branch target address computed in Decode.
REQ-007 rs1_D, rs2_D  in  5 each  source register indices of the Decode instruction.
REQ-008 rd_E, reg_write_E, load_E  in  5/1/1  Execute destination, write-enable, is-load.
REQ-009 rd_M, reg_write_M, load_M  in  5/1/1  Memory destination, write-enable, is-load.
REQ-010 stall_F, stall_D  out  1 each  hold the Fetch PC / Decode register.
REQ-011 flush_D, flush_E  out  1 each  bubble into Decode / Execute at next edge.
REQ-012 redirect, redirect_pc  out  1/32  PC load request and target; registered.
REQ-013 fwd_a_D, fwd_b_D  out  1 each  select Memory-stage ALU result for rs1/rs2 compare operand.
REQ-014 perf_branches, perf_taken  out  PERF_W each  resolved / taken branch counts.

Function
REQ-015 FSM states RUN, REDIRECT; only RUN resolves branches.
REQ-016 dep(rs, rd, we) = we and rd==rs and rs!=0; x0 never causes a hazard or forward.
REQ-017 Hazard (RUN, branchD=1): dep on E for either source (any writer), or dep on M with load_M=1.
REQ-018 Hazard cycle: stall_F=stall_D=flush_E=1, flush_D=0, no resolution, no counter update, state stays RUN.
REQ-019 fwd_x_D=1 iff dep(rs_x, rd_M, reg_write_M) and load_M=0; combinational, independent of state.
REQ-020 Resolve cycle (RUN, branchD=1, no hazard): perf_branches increments at the next edge.
REQ-021 Resolve taken: flush_D=1 this cycle; next edge sets redirect=1, redirect_pc=target_D, perf_taken+1, state -> REDIRECT.
REQ-022 Resolve not taken: no flush, no redirect, state stays RUN.
REQ-023 REDIRECT lasts exactly one cycle: redirect=1, flush_D=1, stalls=0, branchD and hazards ignored; next edge -> RUN, redirect=0.
REQ-024 Net penalty: taken = 2 bubbles; ALU dependency = 1 stall; load in E = 2 stalls.
REQ-025 redirect_pc holds its last value when redirect=0.
REQ-026 Counters saturate at all-ones; no wrap.
REQ-027 branchD=0 in RUN: all stall/flush outputs 0, state unchanged.

Reset
REQ-028 rst=0 forces state RUN, redirect=0, redirect_pc=0, both counters 0, immediately and asynchronously.
REQ-029 Reset asserted in REDIRECT or during a stall aborts it; no pending redirect survives reset.
REQ-030 Combinational outputs follow REQ-027 while in reset.

Structure
REQ-031 Package branch_pkg holds the FSM state enum and the BEQ/BNE/BLT/BGE/BLTU/BGEU funct3 constants.
REQ-032 Hazard and forward detection is one combinational sub-module, branch_hazard; FSM and counters stay in branch_ctrl.

Verification
REQ-033 branchD=1, take_branch=1, target_D=0x0000_0100, no deps -> flush_D=1 cycle N; redirect=1, pc=0x100, flush_D=1 cycle N+1; perf_taken=1.
REQ-034 branchD=1, take_branch=0 -> no flush/redirect; perf_branches=1, perf_taken=0.
REQ-035 rs1_D=5, rd_E=5, load_E=1 -> two stall cycles with flush_E=1, then resolve; rs1_D=0 with rd_E=0 -> no stall.
REQ-036 rs2_D=7, rd_M=7, reg_write_M=1, load_M=0 -> fwd_b_D=1, no stall.
REQ-037 Taken branch, branchD held 1 in REDIRECT cycle -> no second resolution; counters preset to 0xFFFF_FFFF stay saturated.
REQ-038 rst=0 mid-REDIRECT -> redirect=0 immediately, counters 0, RUN after release.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch control slice: FSM state
// encoding, conditional-branch funct3 codes and the register dependency test.
package branch_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // A producer only matters if it writes a real register; x0 is hard-wired zero.
    function automatic logic dep(input logic [4:0] rs, input logic [4:0] rd, input logic we);
        return we && (rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/branch_hazard.sv
// Combinational hazard and forwarding detection for the branch compare
// operands read in Decode.
module branch_hazard
    import branch_pkg::*;
(
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rd_e_i,
    input  logic       reg_write_e_i,
    input  logic       load_e_i,
    input  logic [4:0] rd_m_i,
    input  logic       reg_write_m_i,
    input  logic       load_m_i,
    output logic       hazard_o,
    output logic       fwd_a_o,
    output logic       fwd_b_o
);

    logic we_e;
    logic hz_e;
    logic hz_m;

    // Execute results are never ready for a Decode compare; a load writes its
    // destination, so it counts as a writer even without reg_write_E.
    // Memory results can be forwarded unless the producer is a load.
    always_comb begin
        we_e     = reg_write_e_i | load_e_i;
        hz_e     = dep(rs1_i, rd_e_i, we_e) | dep(rs2_i, rd_e_i, we_e);
        hz_m     = dep(rs1_i, rd_m_i, load_m_i) | dep(rs2_i, rd_m_i, load_m_i);
        hazard_o = hz_e | hz_m;
        fwd_a_o  = dep(rs1_i, rd_m_i, reg_write_m_i) & ~load_m_i;
        fwd_b_o  = dep(rs2_i, rd_m_i, reg_write_m_i) & ~load_m_i;
    end

endmodule

// File: rtl/branch_ctrl.sv
// Decode-stage branch controller: resolves conditional branches, stalls on
// operand hazards, issues a registered PC redirect and counts branches.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branchD,
    input  logic              take_branch,
    input  logic [31:0]       target_D,
    input  logic [4:0]        rs1_D,
    input  logic [4:0]        rs2_D,
    input  logic [4:0]        rd_E,
    input  logic              reg_write_E,
    input  logic              load_E,
    input  logic [4:0]        rd_M,
    input  logic              reg_write_M,
    input  logic              load_M,
    output logic              stall_F,
    output logic              stall_D,
    output logic              flush_D,
    output logic              flush_E,
    output logic              redirect,
    output logic [31:0]       redirect_pc,
    output logic              fwd_a_D,
    output logic              fwd_b_D,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_taken
);

    state_e              state_q, state_d;
    logic                redirect_q, redirect_d;
    logic [31:0]         redirect_pc_q, redirect_pc_d;
    logic [PERF_W-1:0]   perf_branches_q, perf_branches_d;
    logic [PERF_W-1:0]   perf_taken_q, perf_taken_d;
    logic                hazard;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    branch_hazard u_hazard (
        .rs1_i         (rs1_D),
        .rs2_i         (rs2_D),
        .rd_e_i        (rd_E),
        .reg_write_e_i (reg_write_E),
        .load_e_i      (load_E),
        .rd_m_i        (rd_M),
        .reg_write_m_i (reg_write_M),
        .load_m_i      (load_M),
        .hazard_o      (hazard),
        .fwd_a_o       (fwd_a_D),
        .fwd_b_o       (fwd_b_D)
    );

    // Next-state, counter updates and pipeline control for the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d         = state_q;
        redirect_d      = 1'b0;
        redirect_pc_d   = redirect_pc_q;
        perf_branches_d = perf_branches_q;
        perf_taken_d    = perf_taken_q;
        stall_F         = 1'b0;
        stall_D         = 1'b0;
        flush_D         = 1'b0;
        flush_E         = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (branchD && rst) begin
                    if (hazard) begin
                        stall_F = 1'b1;
                        stall_D = 1'b1;
                        flush_E = 1'b1;
                    end else begin
                        perf_branches_d = sat_inc(perf_branches_q);
                        if (take_branch) begin
                            flush_D       = 1'b1;
                            redirect_d    = 1'b1;
                            redirect_pc_d = target_D;
                            perf_taken_d  = sat_inc(perf_taken_q);
                            state_d       = ST_REDIRECT;
                        end
                    end
                end
            end
            ST_REDIRECT: begin
                // The wrong-path instruction in Fetch is squashed; Decode is ignored.
                flush_D = 1'b1;
                state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and counter registers; reset clears any pending redirect at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_RUN;
            redirect_q      <= 1'b0;
            redirect_pc_q   <= 32'd0;
            perf_branches_q <= '0;
            perf_taken_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q         <= state_d;
            redirect_q      <= redirect_d;
            redirect_pc_q   <= redirect_pc_d;
            perf_branches_q <= perf_branches_d;
            perf_taken_q    <= perf_taken_d;
        end
    end

    assign redirect      = redirect_q;
    assign redirect_pc   = redirect_pc_q;
    assign perf_branches = perf_branches_q;
    assign perf_taken    = perf_taken_q;

endmodule
